button_debounce_bank: RTL and testbench
=======================================

Name: button_debounce_bank

Overview:
Conditioning stage directly upstream of the riding-position LED/buzzer logic. Synchronises five raw mechanical button inputs (drops, hoods, tops, bar, seat) into the clk domain and debounces each one. Emits clean levels, single-cycle press/release strobes, and an encoded current hand position for the downstream indicator block.

Parameters:
N_BTN, 5, number of button channels (bit order: 0 drops, 1 hoods, 2 tops, 3 bar, 4 seat)
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); legal range ≥ 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
btn_raw  in  N_BTN  asynchronous raw button levels, 1 = pressed
btn_level  out  N_BTN  debounced stable level per channel
btn_press  out  N_BTN  1-cycle strobe on accepted 0->1
btn_release  out  N_BTN  1-cycle strobe on accepted 1->0
pos_code  out  3  index of the single pressed button; 7 = none or invalid
pos_valid  out  1  exactly one btn_level bit set
pos_change  out  1  1-cycle strobe when pos_code changes value

Behaviour:
- Reset: reset and clock are as already decided (one clock; synchronous, active-low reset). While rst_n = 0 at a clk edge, clear all synchroniser flops, counters, btn_level, btn_press, btn_release, pos_valid and pos_change. Set pos_code = 7. The first post-reset cycle therefore reports no button pressed.
- Synchroniser: each btn_raw bit passes through 2 flops (sync1 -> sync2). No logic sits between the two flops.
- Per channel, counter cnt[CNT_W]:
  - If sync2 == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= sync2 and cnt <= 0. In the same edge, register btn_press (new level 1) or btn_release (new level 0) high for exactly 1 cycle.
  - Else: cnt <= cnt + 1.
- Any bounce back to the current btn_level clears cnt. The DEBOUNCE_CYCLES stable cycles must be consecutive.
- Latency from a clean btn_raw edge to btn_level/strobe: 2 + DEBOUNCE_CYCLES clk cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Channels are fully independent. Several channels may accept in the same cycle, and each raises its own strobe.
- Counter never wraps. It is bounded by the compare at DEBOUNCE_CYCLES-1.
- Position encoder, registered one cycle after btn_level:
  - pos_valid = (popcount(btn_level) == 1).
  - pos_code = index of the set bit when pos_valid; otherwise 7.
- pos_change goes high for 1 cycle when the newly registered pos_code differs from its previous value. This includes transitions to and from 7.
- Encoder timing relative to the accepting edge:
  - btn_press/btn_release appear at edge N.
  - pos_code/pos_valid update at edge N+1.
  - pos_change asserts in the cycle following edge N+1.
- Simultaneous press of a second button: pos_valid drops, pos_code goes to 7, pos_change fires.
- Reset mid-debounce: the partial count is discarded, and the input must be re-qualified from zero after reset releases.

Decomposition:
- Shared package btn_pkg holds:
  - Channel index constants BTN_DROPS=0, BTN_HOODS=1, BTN_TOPS=2, BTN_BAR=3, BTN_SEAT=4.
  - POS_NONE=3'd7.
  - Default DEBOUNCE_CYCLES.
- One sub-module, debounce_channel (sync flops, counter, level, press/release), instantiated N_BTN times via generate.
- The position encoder lives in the top level.

Test Plan (sim with DEBOUNCE_CYCLES=4):
- Reset, then hold btn_raw=5'b00000 for 20 cycles -> btn_level=0, no strobes, pos_code=7, pos_valid=0, pos_change=0.
- Raise btn_raw[1] cleanly -> btn_level[1]=1 and btn_press[1] pulses for 1 cycle exactly 6 cycles after the edge. Next cycle: pos_code=1, pos_valid=1. Cycle after: pos_change pulses.
- Toggle btn_raw[0] 1,0,1,0 with 3-cycle high phases, then hold 0 -> btn_level[0] never rises, no btn_press[0].
- With hoods held, press btn_raw[4] -> btn_press[4] pulses, pos_valid=0, pos_code=7, pos_change pulses. Release hoods -> btn_release[1] pulses, pos_code=4, pos_valid=1.
- Raise btn_raw[2] and btn_raw[3] on the same edge -> both btn_press bits pulse in the same cycle, pos_code=7.
- Assert rst_n=0 after 2 qualifying cycles of a press, release reset while the input stays high -> press accepted 6 cycles after reset release, not earlier.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the riding-position button conditioning stage:
// channel indices, the "no position" code and default debounce sizing.
package btn_pkg;

  localparam int unsigned BTN_DROPS = 0;
  localparam int unsigned BTN_HOODS = 1;
  localparam int unsigned BTN_TOPS  = 2;
  localparam int unsigned BTN_BAR   = 3;
  localparam int unsigned BTN_SEAT  = 4;

  localparam logic [2:0] POS_NONE = 3'd7;

  // 10 ms of stability at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT           = 20;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser followed by a consecutive-stable
// counter that accepts a new level and emits single-cycle press/release strobes.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rls_q, rls_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rls_d   = 1'b0;
    // Any sample matching the current level restarts qualification.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
      rls_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rls_q   <= rls_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rls   = rls_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounced button channels plus a registered encoder
// reporting which single hand position is held, with a change strobe.
module button_debounce_bank
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [2:0]       pos_code,
  output logic             pos_valid,
  output logic             pos_change
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .press (btn_press[g]),
      .rls   (btn_release[g])
    );
  end

  logic [2:0] pos_code_q, pos_code_d;
  logic       pos_valid_q, pos_valid_d;
  logic [2:0] pos_prev_q, pos_prev_d;
  logic       pos_change_q, pos_change_d;

  always_comb begin
    int unsigned ones;
    logic [2:0]  idx;
    ones = 0;
    idx  = POS_NONE;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (btn_level[i]) begin
        ones = ones + 1;
        idx  = 3'(i);
      end
    end
    pos_valid_d  = (ones == 1);
    pos_code_d   = pos_valid_d ? idx : POS_NONE;
    // Change is judged on the registered code, so it trails pos_code by a cycle.
    pos_prev_d   = pos_code_q;
    pos_change_d = (pos_code_q != pos_prev_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_code_q   <= POS_NONE;
      pos_valid_q  <= 1'b0;
      pos_prev_q   <= POS_NONE;
      pos_change_q <= 1'b0;
    end else begin
      pos_code_q   <= pos_code_d;
      pos_valid_q  <= pos_valid_d;
      pos_prev_q   <= pos_prev_d;
      pos_change_q <= pos_change_d;
    end
  end

  assign pos_code   = pos_code_q;
  assign pos_valid  = pos_valid_q;
  assign pos_change = pos_change_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench for button_debounce_bank with a 4-cycle debounce window:
// expected output snapshots are queued per cycle and checked at negedge.
module tb_button_debounce_bank;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release;
  logic [2:0] pos_code;
  logic       pos_valid, pos_change;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t sb[$];

  button_debounce_bank #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .pos_code    (pos_code),
    .pos_valid   (pos_valid),
    .pos_change  (pos_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] outs();
    return {btn_level, btn_press, btn_release, pos_code, pos_valid, pos_change};
  endfunction

  function automatic logic [19:0] mk(input logic [4:0] lv, input logic [4:0] pr,
                                     input logic [4:0] rl, input logic [2:0] code,
                                     input logic vld, input logic chg);
    return {lv, pr, rl, code, vld, chg};
  endfunction

  task automatic push(input int c, input string n, input logic [19:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int   base;
    exp_t e;
    base = cyc + 1;
    push(base + 2,  "reset_state", mk(5'b0, 5'b0, 5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 22, "idle_20",     mk(5'b0, 5'b0, 5'b0, 3'd7, 1'b0, 1'b0));
    for (int i = 0; i <= 22; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      rst_n   = (i >= 2);
      btn_raw = 5'b0;
    end
  endtask

  task automatic test_press_hoods();
    int   base;
    exp_t e;
    base = cyc + 1;
    push(base + 5, "hoods_not_early", mk(5'b00000, 5'b00000, 5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 6, "hoods_press",     mk(5'b00010, 5'b00010, 5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 7, "hoods_pos",       mk(5'b00010, 5'b00000, 5'b0, 3'd1, 1'b1, 1'b0));
    push(base + 8, "hoods_change",    mk(5'b00010, 5'b00000, 5'b0, 3'd1, 1'b1, 1'b1));
    push(base + 9, "hoods_settled",   mk(5'b00010, 5'b00000, 5'b0, 3'd1, 1'b1, 1'b0));
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      if (i == 0) btn_raw[1] = 1'b1;
    end
  endtask

  task automatic test_glitch();
    int   base;
    exp_t e;
    base = cyc + 1;
    for (int k = 4; k <= 20; k += 4)
      push(base + k, $sformatf("glitch_%0d", k), mk(5'b00010, 5'b0, 5'b0, 3'd1, 1'b1, 1'b0));
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      btn_raw[0] = (i < 3) || (i >= 6 && i < 9);
    end
  endtask

  task automatic test_second_button();
    int   base;
    exp_t e;
    base = cyc + 1;
    push(base + 6,  "seat_press",    mk(5'b10010, 5'b10000, 5'b00000, 3'd1, 1'b1, 1'b0));
    push(base + 7,  "seat_invalid",  mk(5'b10010, 5'b00000, 5'b00000, 3'd7, 1'b0, 1'b0));
    push(base + 8,  "seat_change",   mk(5'b10010, 5'b00000, 5'b00000, 3'd7, 1'b0, 1'b1));
    push(base + 16, "hoods_release", mk(5'b10000, 5'b00000, 5'b00010, 3'd7, 1'b0, 1'b0));
    push(base + 17, "seat_only_pos", mk(5'b10000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0));
    push(base + 18, "seat_only_chg", mk(5'b10000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b1));
    for (int i = 0; i <= 19; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      if (i == 0)  btn_raw[4] = 1'b1;
      if (i == 10) btn_raw[1] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int   base;
    exp_t e;
    base = cyc + 1;
    push(base + 6, "dual_press",  mk(5'b11100, 5'b01100, 5'b0, 3'd4, 1'b1, 1'b0));
    push(base + 7, "dual_pos",    mk(5'b11100, 5'b00000, 5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 8, "dual_change", mk(5'b11100, 5'b00000, 5'b0, 3'd7, 1'b0, 1'b1));
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      if (i == 0) btn_raw[3:2] = 2'b11;
    end
  endtask

  task automatic test_reset_mid();
    int   base;
    exp_t e;
    base = cyc + 1;
    push(base + 1,  "rst_clear",     mk(5'b0,     5'b0,     5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 3,  "rst_released",  mk(5'b0,     5'b0,     5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 11, "rst_mid",       mk(5'b0,     5'b0,     5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 16, "requal_early",  mk(5'b0,     5'b0,     5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 17, "requal_press",  mk(5'b00010, 5'b00010, 5'b0, 3'd7, 1'b0, 1'b0));
    push(base + 18, "requal_pos",    mk(5'b00010, 5'b00000, 5'b0, 3'd1, 1'b1, 1'b0));
    push(base + 19, "requal_change", mk(5'b00010, 5'b00000, 5'b0, 3'd1, 1'b1, 1'b1));
    for (int i = 0; i <= 22; i++) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || outs() !== e.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got %h want %h (due %0d)", e.name, cyc, outs(), e.v, e.cyc);
        end
      end
      if (i == 0) begin
        rst_n   = 1'b0;
        btn_raw = 5'b0;
      end
      if (i == 2)  rst_n = 1'b1;
      if (i == 5)  btn_raw[1] = 1'b1;
      if (i == 9)  rst_n = 1'b0;
      if (i == 11) rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 5'b0;
    test_reset();
    test_press_hoods();
    test_glitch();
    test_second_button();
    test_back_to_back();
    test_reset_mid();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s never checked: got none want %h (due %0d)", e.name, e.v, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
